// File: rtl/mm_sched_pkg.sv
// rtl/mm_sched_pkg.sv - MMIO map, flag codes, state encoding and fetch table for mm_job_sched
package mm_sched_pkg;

  localparam logic [31:0] MATMUL_A_IN  = 32'h000;
  localparam logic [31:0] MATMUL_B_IN  = 32'h100;
  localparam logic [31:0] MATMUL_C_OUT = 32'h200;
  localparam logic [31:0] MATVEC_A_IN  = 32'h300;
  localparam logic [31:0] MATVEC_B_IN  = 32'h400;
  localparam logic [31:0] MATVEC_C_OUT = 32'h500;
  localparam logic [31:0] M_DIM        = 32'h600;
  localparam logic [31:0] N_DIM        = 32'h700;
  localparam logic [31:0] P_DIM        = 32'h800;
  localparam logic [31:0] MATMUL_FLAG  = 32'hA00;
  localparam logic [31:0] MATVEC_FLAG  = 32'hB00;
  localparam logic [31:0] BIAS_ADDR    = 32'hD00;

  localparam logic [31:0] FLAG_IDLE = 32'd0;
  localparam logic [31:0] FLAG_POST = 32'd1;
  localparam logic [31:0] FLAG_DONE = 32'd2;
  localparam logic [31:0] FLAG_ERR  = 32'd3;

  typedef enum logic [3:0] {
    ST_GAP,
    ST_POLL,
    ST_CHECK,
    ST_POLL_MV,
    ST_CHECK_MV,
    ST_FETCH,
    ST_VALID,
    ST_START,
    ST_RUN,
    ST_WB
  } sched_state_t;

  // Read k of a fetch lands in field k: A, B, C, bias, M, N, P (matvec stops before P).
  function automatic logic [31:0] fetch_addr(input logic mv, input logic [2:0] k);
    case (k)
      3'd0:    return mv ? MATVEC_A_IN  : MATMUL_A_IN;
      3'd1:    return mv ? MATVEC_B_IN  : MATMUL_B_IN;
      3'd2:    return mv ? MATVEC_C_OUT : MATMUL_C_OUT;
      3'd3:    return BIAS_ADDR;
      3'd4:    return M_DIM;
      3'd5:    return N_DIM;
      default: return P_DIM;
    endcase
  endfunction

endpackage

// File: rtl/mm_job_sched_rr_arb2.sv
// rtl/mm_job_sched_rr_arb2.sv - two-way round-robin arbiter, present only with MATVEC_SCHED_EN
`ifdef MATVEC_SCHED_EN
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_mv;

  always_comb begin
    grant = '0;
    if (prio_mv) grant = {req[1], req[0] & ~req[1]};
    else         grant = {req[1] & ~req[0], req[0]};
  end

  // Priority flips after every granted job, matmul first out of reset.
  always_ff @(posedge clk) begin
    if (rst)          prio_mv <= 1'b0;
    else if (advance) prio_mv <= ~prio_mv;
  end

endmodule
`endif

// File: rtl/mm_job_sched.sv
// rtl/mm_job_sched.sv - polls the MMIO job flag, fetches and validates operands, launches the engine.
// MATVEC_SCHED_EN adds a matvec flag poll, round-robin arbitration and the eng_sel output.
module mm_job_sched
  import mm_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16,
  parameter int MAX_DIM    = 64,
  parameter int POLL_GAP   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  eng_start,
  output logic [31:0]           eng_a_addr,
  output logic [31:0]           eng_b_addr,
  output logic [31:0]           eng_c_addr,
  output logic [31:0]           eng_bias_addr,
  output logic [DIM_WIDTH-1:0]  eng_m,
  output logic [DIM_WIDTH-1:0]  eng_n,
  output logic [DIM_WIDTH-1:0]  eng_p,
  input  logic                  eng_done,
`ifdef MATVEC_SCHED_EN
  output logic                  eng_sel,
`endif
  output logic                  busy
);

  localparam int GW = $clog2(POLL_GAP + 1);

  sched_state_t   state, next_state;
  logic [GW-1:0]  gap_cnt;
  logic [2:0]     fetch_k, fetch_last;
  logic [31:0]    m_val, n_val, p_val;
  logic           err, legal, post_seen, job_mv;

  assign post_seen  = (mem_q == DATA_WIDTH'(FLAG_POST));
  assign fetch_last = job_mv ? 3'd6 : 3'd7;
  // Validation uses the full fetched word so oversized values cannot alias after truncation.
  assign legal = (m_val != 32'd0) && (m_val <= 32'(MAX_DIM)) &&
                 (n_val != 32'd0) && (n_val <= 32'(MAX_DIM)) &&
                 (p_val != 32'd0) && (p_val <= 32'(MAX_DIM));

  assign eng_m = m_val[DIM_WIDTH-1:0];
  assign eng_n = n_val[DIM_WIDTH-1:0];
  assign eng_p = p_val[DIM_WIDTH-1:0];

`ifdef MATVEC_SCHED_EN
  logic       req_mm, advance;
  logic [1:0] req, grant;

  assign req     = {post_seen, req_mm};
  assign advance = (state == ST_CHECK_MV) && (|req);
  assign eng_sel = job_mv;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );
`else
  assign job_mv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_GAP;
      gap_cnt       <= '0;
      fetch_k       <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      eng_a_addr    <= '0;
      eng_b_addr    <= '0;
      eng_c_addr    <= '0;
      eng_bias_addr <= '0;
      m_val         <= '0;
      n_val         <= '0;
      p_val         <= '0;
`ifdef MATVEC_SCHED_EN
      job_mv        <= 1'b0;
      req_mm        <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        ST_GAP: gap_cnt <= gap_cnt + 1'b1;
`ifdef MATVEC_SCHED_EN
        ST_CHECK: req_mm <= post_seen;
        ST_CHECK_MV: begin
          if (|grant) begin
            busy    <= 1'b1;
            fetch_k <= '0;
            job_mv  <= grant[1];
          end else begin
            gap_cnt <= '0;
          end
        end
`else
        ST_CHECK: begin
          if (post_seen) begin
            busy    <= 1'b1;
            fetch_k <= '0;
          end else begin
            gap_cnt <= '0;
          end
        end
`endif
        ST_FETCH: begin
          fetch_k <= fetch_k + 3'd1;
          if (fetch_k == 3'd0 && job_mv) p_val <= 32'd1;
          // Read data trails its address by one cycle, so slot k holds read k-1.
          case (fetch_k)
            3'd1:    eng_a_addr    <= 32'(mem_q);
            3'd2:    eng_b_addr    <= 32'(mem_q);
            3'd3:    eng_c_addr    <= 32'(mem_q);
            3'd4:    eng_bias_addr <= 32'(mem_q);
            3'd5:    m_val         <= 32'(mem_q);
            3'd6:    n_val         <= 32'(mem_q);
            3'd7:    p_val         <= 32'(mem_q);
            default: ;
          endcase
        end
        ST_VALID: err <= !legal;
        ST_WB: begin
          busy    <= 1'b0;
          gap_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    eng_start  = 1'b0;
    case (state)
      ST_GAP:   if (gap_cnt == GW'(POLL_GAP - 1)) next_state = ST_POLL;
      ST_POLL: begin
        mem_addr   = ADDR_WIDTH'(MATMUL_FLAG);
        next_state = ST_CHECK;
      end
`ifdef MATVEC_SCHED_EN
      ST_CHECK: next_state = ST_POLL_MV;
      ST_POLL_MV: begin
        mem_addr   = ADDR_WIDTH'(MATVEC_FLAG);
        next_state = ST_CHECK_MV;
      end
      ST_CHECK_MV: next_state = (|grant) ? ST_FETCH : ST_GAP;
`else
      ST_CHECK: next_state = post_seen ? ST_FETCH : ST_GAP;
`endif
      ST_FETCH: begin
        if (fetch_k == fetch_last) next_state = ST_VALID;
        else mem_addr = ADDR_WIDTH'(fetch_addr(job_mv, fetch_k));
      end
      ST_VALID: next_state = legal ? ST_START : ST_WB;
      ST_START: begin
        eng_start  = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN:   if (eng_done) next_state = ST_WB;
      ST_WB: begin
        mem_addr   = ADDR_WIDTH'(job_mv ? MATVEC_FLAG : MATMUL_FLAG);
        mem_wdata  = DATA_WIDTH'(err ? FLAG_ERR : FLAG_DONE);
        mem_we     = 1'b1;
        next_state = ST_GAP;
      end
      default:  next_state = ST_GAP;
    endcase
  end

endmodule

// File: tb/tb_mm_job_sched.sv
// tb/tb_mm_job_sched.sv - directed self-checking bench for mm_job_sched with a 1-cycle-latency MMIO model
module tb_mm_job_sched;

`ifdef MATVEC_SCHED_EN
  localparam int LAT = 13, POLLS40 = 3, SPAN = 24;
`else
  localparam int LAT = 11, POLLS40 = 4, SPAN = 30;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_q;
  logic        mem_we, eng_start, eng_done, busy;
  logic [31:0] eng_a_addr, eng_b_addr, eng_c_addr, eng_bias_addr;
  logic [15:0] eng_m, eng_n, eng_p;
`ifdef MATVEC_SCHED_EN
  logic        eng_sel;
`endif

  logic [31:0] mem [16];
  int checks = 0, errors = 0;
  int cyc = 0, poll_cnt = 0, first_poll = -1, last_poll = 0, start_poll = 0, start_cyc = 0;
  int start_cnt = 0, wr_cnt = 0;

  always #5 clk = ~clk;

  mm_job_sched #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DIM_WIDTH(16), .MAX_DIM(64), .POLL_GAP(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_q         (mem_q),
    .eng_start     (eng_start),
    .eng_a_addr    (eng_a_addr),
    .eng_b_addr    (eng_b_addr),
    .eng_c_addr    (eng_c_addr),
    .eng_bias_addr (eng_bias_addr),
    .eng_m         (eng_m),
    .eng_n         (eng_n),
    .eng_p         (eng_p),
    .eng_done      (eng_done),
`ifdef MATVEC_SCHED_EN
    .eng_sel       (eng_sel),
`endif
    .busy          (busy)
  );

  always @(posedge clk) begin
    mem_q <= mem[mem_addr[11:8]];
    if (mem_we) mem[mem_addr[11:8]] = mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_addr == 32'hA00 && !mem_we) begin
      poll_cnt++;
      if (first_poll < 0) first_poll = cyc;
      last_poll = cyc;
    end
    if (eng_start) begin
      start_cnt++;
      start_cyc  = cyc;
      start_poll = last_poll;
    end
    if (mem_we) wr_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (eng_start) break;
      step(1);
    end
    check(tag, eng_start, 1);
  endtask

  task automatic wait_we(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (mem_we) break;
      step(1);
    end
    check(tag, mem_we, 1);
  endtask

  task automatic finish_job(input string tag, input logic [31:0] flag_addr);
    step(19);
    eng_done = 1'b1;
    step(1);
    eng_done = 1'b0;
    check({tag, "_we"}, mem_we, 1);
    check({tag, "_wb_addr"}, mem_addr, flag_addr);
    check({tag, "_wb_data"}, mem_wdata, 2);
    step(1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_we_low"}, mem_we, 0);
  endtask

  task automatic run_job(input string tag, input logic [31:0] m, input logic [31:0] n,
                         input logic [31:0] p);
    int wr0, st0;
    mem[6] = m; mem[7] = n; mem[8] = p; mem[10] = 32'd1;
    wr0 = wr_cnt; st0 = start_cnt;
    wait_start({tag, "_start"});
    check({tag, "_a"}, eng_a_addr, 32'h1000);
    check({tag, "_b"}, eng_b_addr, 32'h2000);
    check({tag, "_c"}, eng_c_addr, 32'h3000);
    check({tag, "_bias"}, eng_bias_addr, 32'h4000);
    check({tag, "_m"}, eng_m, m[15:0]);
    check({tag, "_n"}, eng_n, n[15:0]);
    check({tag, "_p"}, eng_p, p[15:0]);
    check({tag, "_busy"}, busy, 1);
    step(1);
    check({tag, "_one_pulse"}, eng_start, 0);
    check({tag, "_latency"}, start_cyc - start_poll, LAT);
    check({tag, "_start_cnt"}, start_cnt, st0 + 1);
    finish_job(tag, 32'hA00);
    check({tag, "_flag"}, mem[10], 2);
    check({tag, "_wr_cnt"}, wr_cnt, wr0 + 1);
  endtask

  task automatic run_err(input string tag, input logic [31:0] m, input logic [31:0] n,
                         input logic [31:0] p);
    int st0;
    mem[6] = m; mem[7] = n; mem[8] = p; mem[10] = 32'd1;
    st0 = start_cnt;
    wait_we({tag, "_wb"});
    check({tag, "_wb_addr"}, mem_addr, 32'hA00);
    check({tag, "_wb_data"}, mem_wdata, 3);
    check({tag, "_no_start"}, start_cnt, st0);
    step(1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int wr0, st0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    eng_done = 1'b0;
    step(3);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_start", eng_start, 0);
    check("rst_busy", busy, 0);
    check("rst_a", eng_a_addr, 0);
    check("rst_m", eng_m, 0);

    cyc = 0; poll_cnt = 0; first_poll = -1; wr_cnt = 0; start_cnt = 0;
    rst = 1'b0;
    step(40);
    check("idle_polls", poll_cnt, POLLS40);
    check("idle_first_poll", first_poll, 8);
    check("idle_poll_span", last_poll - first_poll, SPAN);
    check("idle_no_start", start_cnt, 0);
    check("idle_no_write", wr_cnt, 0);

    mem[0] = 32'h1000; mem[1] = 32'h2000; mem[2] = 32'h3000; mem[13] = 32'h4000;
    run_job("job", 32'd4, 32'd8, 32'd2);
    run_job("job_max", 32'd64, 32'd1, 32'd64);

    run_err("err_m0", 32'd0, 32'd8, 32'd2);
    run_err("err_p65", 32'd4, 32'd8, 32'd65);
    run_err("err_n_wide", 32'd4, 32'h0001_0004, 32'd2);

    mem[6] = 32'd4; mem[7] = 32'd8; mem[8] = 32'd2; mem[10] = 32'd1;
    wait_start("rr_start");
    wr0 = wr_cnt;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rr_addr", mem_addr, 0);
    check("rr_we", mem_we, 0);
    check("rr_start_low", eng_start, 0);
    check("rr_busy", busy, 0);
    check("rr_a", eng_a_addr, 0);
    check("rr_m", eng_m, 0);
    check("rr_flag_kept", mem[10], 1);
    check("rr_no_write", wr_cnt, wr0);
    wait_start("rr_refetch");
    check("rr_refetch_a", eng_a_addr, 32'h1000);
    step(1);
    finish_job("rr_done", 32'hA00);

    wr0 = wr_cnt; st0 = start_cnt;
    eng_done = 1'b1;
    step(1);
    eng_done = 1'b0;
    step(30);
    check("gap_done_no_write", wr_cnt, wr0);
    check("gap_done_no_start", start_cnt, st0);

`ifdef MATVEC_SCHED_EN
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    mem[3] = 32'h5000; mem[4] = 32'h6000; mem[5] = 32'h7000;
    mem[6] = 32'd3; mem[7] = 32'd5; mem[8] = 32'd2;
    mem[10] = 32'd1; mem[11] = 32'd1;
    wait_start("mv_first");
    check("mv_first_sel", eng_sel, 0);
    check("mv_first_a", eng_a_addr, 32'h1000);
    check("mv_first_p", eng_p, 2);
    step(1);
    finish_job("mv_first", 32'hA00);
    wait_start("mv_second");
    check("mv_second_sel", eng_sel, 1);
    check("mv_second_a", eng_a_addr, 32'h5000);
    check("mv_second_c", eng_c_addr, 32'h7000);
    check("mv_second_p", eng_p, 1);
    step(1);
    finish_job("mv_second", 32'hB00);
    check("mv_flag_b", mem[11], 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_job_sched.md
Name: mm_job_sched

Overview:
- Hardware job sequencer for the accelerator MMIO register file.
- Drives one port of the memory-map block and polls the matmul flag register.
- When the host posts a job, it fetches operand addresses and dimensions, validates them, and launches the matmul engine.
- When the engine signals done, it writes completion or error status back to the flag register.

Parameters:
- DATA_WIDTH, 32, MMIO/SRAM data width.
- ADDR_WIDTH, 32, memory-map address width.
- DIM_WIDTH, 16, width of each dimension bus to the engine.
- MAX_DIM, 64, largest legal value of M, N and P.
- POLL_GAP, 8, idle cycles between flag polls (frees the port for other masters).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_addr  out  ADDR_WIDTH  memory-map port address
- mem_wdata  out  DATA_WIDTH  write data
- mem_we  out  1  write enable
- mem_q  in  DATA_WIDTH  read data, valid 1 cycle after the address
- eng_start  out  1  one-cycle launch pulse
- eng_a_addr / eng_b_addr / eng_c_addr / eng_bias_addr  out  32 each  operand base addresses
- eng_m / eng_n / eng_p  out  DIM_WIDTH each  dimensions
- eng_done  in  1  engine completion pulse
- busy  out  1  high from job detection until status writeback completes

Behaviour:
- Reset: every output 0, state GAP, gap counter 0. A reset asserted mid-job aborts to GAP with no writeback; the engine is reset separately.
- Flag protocol:
  - Host writes 1 to post a job.
  - Scheduler writes 2 on done, 3 on validation error.
  - Values 0, 2 and 3 are ignored when polled.
- GAP: mem_addr=0, mem_we=0. Count POLL_GAP cycles, then go to POLL.
- POLL (1 cycle): mem_addr=0xA00. Go to CHECK.
- CHECK (1 cycle): sample mem_q.
  - If mem_q==1: busy<=1, go to FETCH.
  - Otherwise reload the gap counter and go to GAP.
- FETCH (8 cycles, index k=0..7):
  - For k<7, drive mem_addr from the sequence 0x000, 0x100, 0x200, 0xD00, 0x600, 0x700, 0x800.
  - For k≥1, capture mem_q into the field of read k-1.
  - Go to VALID.
- VALID (1 cycle): the job is legal iff M, N and P are each in 1..MAX_DIM (full 32-bit compare).
  - Legal: go to START.
  - Illegal: status=3, go to WB.
- START (1 cycle): eng_start=1. eng_* buses are driven from captured values and held stable until the next FETCH. Dims are truncated to DIM_WIDTH after validation. Go to RUN.
- RUN: wait for eng_done; then status=2, go to WB.
  - eng_done outside RUN is ignored.
  - No timeout.
- WB (1 cycle): mem_addr=0xA00, mem_wdata=status, mem_we=1. busy<=0, reload gap counter, go to GAP.
- mem_we is high only in WB. mem_addr is 0 in GAP/RUN/START/VALID.
- Post-to-start latency: 11 cycles from the POLL cycle that reads 1.

Optional Feature:
- Macro: MATVEC_SCHED_EN.
- Defined:
  - Also polls MATVEC_Flag at 0xB00 in a second POLL/CHECK pair immediately after the matmul pair.
  - Operands come from 0x300, 0x400, 0x500, 0xD00, 0x600, 0x700; P is forced to 1 and not read (FETCH lasts 7 cycles).
  - Matvec jobs add outputs eng_sel (0=matmul, 1=matvec) and use the same eng_start/eng_done.
  - If both flags read 1 in the same poll round, round-robin priority applies, starting with matmul after reset and toggling after each granted job.
  - Status is written back to the granted job's flag address.
- Undefined: matmul only, eng_sel absent, 0xB00 never accessed.

Decomposition:
- Package mm_sched_pkg holds:
  - MMIO address constants (MATMUL_A_IN=0x000 … BIAS_ADDR=0xD00).
  - Flag encodings FLAG_IDLE=0, FLAG_POST=1, FLAG_DONE=2, FLAG_ERR=3.
  - The state enum.
  - The fetch-sequence address table.
- No sub-module except, under MATVEC_SCHED_EN, a 2-way round-robin arbiter rr_arb2 (req[1:0], grant[1:0], advance pulse).

Test Plan:
- Flag 0, 40 cycles → no eng_start, no mem_we; mem_addr 0xA00 exactly once per POLL_GAP+2 cycles.
- Registers A=0x1000, B=0x2000, C=0x3000, bias=0x4000, M=4, N=8, P=2, flag=1:
  - eng_start one cycle, 11 cycles after the POLL that reads 1, with those values on the eng_* buses.
  - eng_done 20 cycles later → one-cycle write of 2 to 0xA00, busy falls.
- M=0 (or P=65 with MAX_DIM=64), flag=1 → no eng_start; write of 3 to 0xA00.
- rst pulsed 3 cycles into RUN → all outputs 0 next cycle, no flag writeback; flag still 1, so the job is re-fetched after POLL_GAP.
- eng_done pulsed while in GAP → ignored; no write.
- MATVEC_SCHED_EN with both flags=1 → matmul granted first (0xA00←2), then matvec (eng_sel=1, eng_p=1, 0xB00←2).
